// File: rtl/mac_sequencer.sv
// Instruction sequencer: 8-deep instruction FIFO feeding a MAC datapath over a valid/ready issue port.
// Latency: an instruction pushed into an empty FIFO at edge N is popped at N+1; dp_valid is high from N+1.
// Backpressure: instr_ready drops at 8 entries; dp_ready stalls ISSUE up to TIMEOUT cycles, then abort to HALT.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   run, flush, clear_err        pop enable, FIFO flush, HALT exit
//   instr_in/instr_valid/instr_ready   instruction push port ([7:6] opcode, [5:0] operand)
//   dp_op/dp_operand/dp_valid/dp_ready issue port to the MAC datapath
//   fifo_count, busy, issued_count, err_timeout   status
module mac_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       flush,
    input  logic       clear_err,
    input  logic [7:0] instr_in,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [1:0] dp_op,
    output logic [5:0] dp_operand,
    output logic       dp_valid,
    input  logic       dp_ready,
    output logic [3:0] fifo_count,
    output logic       busy,
    output logic [7:0] issued_count,
    output logic       err_timeout
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      mem [8];
    logic [2:0]      wr_ptr;
    logic [2:0]      rd_ptr;
    logic [3:0]      count;
    logic [7:0]      head;
    logic            push;

    logic            pop;
    logic            load;
    logic            hs;
    logic            abort;
    logic            clr;
    logic [WW-1:0]   wait_cnt;

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    // Ready comes only from registered occupancy, so a pop in the same
    // cycle never opens a slot for a push at count 8.
    assign instr_ready = (count != 4'd8);
    assign push        = instr_valid && instr_ready && !flush;
    assign head        = mem[rd_ptr];
    assign fifo_count  = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count  <= 4'd0;
        end else if (flush) begin
            // pop is already suppressed by flush in the FSM
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        hs        = 1'b0;
        abort     = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (run && (count != 4'd0) && !flush) begin
                    pop = 1'b1;
                    // NOP is retired by the pop alone
                    if (head[7:6] != 2'b00) begin
                        load      = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // a handshake in the last allowed cycle wins over the abort
                if (dp_ready) begin
                    hs        = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (clear_err) begin
                    clr       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue registers, wait counter, status
    // ------------------------------------------------------------------
    assign dp_valid = (state == ISSUE);
    assign busy     = (state != IDLE) || (count != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_op        <= 2'd0;
            dp_operand   <= 6'd0;
            wait_cnt     <= '0;
            issued_count <= 8'd0;
            err_timeout  <= 1'b0;
        end else begin
            if (load) begin
                dp_op      <= head[7:6];
                dp_operand <= head[5:0];
            end

            // counts ISSUE cycles that ended without a handshake
            if ((state == ISSUE) && !hs && !abort) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (hs) begin
                issued_count <= issued_count + 8'd1;
            end

            if (abort) begin
                err_timeout <= 1'b1;
            end else if (clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       flush;
    logic       clear_err;
    logic [7:0] instr_in;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] dp_op;
    logic [5:0] dp_operand;
    logic       dp_valid;
    logic       dp_ready;
    logic [3:0] fifo_count;
    logic       busy;
    logic [7:0] issued_count;
    logic       err_timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] log_q [$];
    int         nop_seen = 0;
    int         b2b = 0;
    logic       prev_hs = 1'b0;

    mac_sequencer #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .flush        (flush),
        .clear_err    (clear_err),
        .instr_in     (instr_in),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .dp_op        (dp_op),
        .dp_operand   (dp_operand),
        .dp_valid     (dp_valid),
        .dp_ready     (dp_ready),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .issued_count (issued_count),
        .err_timeout  (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every completed handshake; flag NOP issues and back-to-back issue.
    always @(posedge clk) begin
        if (rst_n && dp_valid && dp_op == 2'b00) nop_seen++;
        if (rst_n && dp_valid && prev_hs) b2b++;
        prev_hs = rst_n && dp_valid && dp_ready;
        if (rst_n && dp_valid && dp_ready) log_q.push_back({dp_op, dp_operand});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_one(input logic [7:0] v);
        instr_valid = 1'b1;
        instr_in    = v;
        tick(1);
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; flush = 1'b0; clear_err = 1'b0;
        instr_in = 8'h00; instr_valid = 1'b0; dp_ready = 1'b0;
        #1;
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_instr_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_issued", issued_count, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_dp_op", {dp_op, dp_operand}, 0);
        #2 rst_n = 1'b1;
        tick(1);

        // Ordered issue of a mixed program
        run = 1'b1; dp_ready = 1'b1;
        log_q.delete();
        push_one(8'h41); push_one(8'h42); push_one(8'h81); push_one(8'h82); push_one(8'hC0);
        tick(15);
        chk("prog_len", log_q.size(), 5);
        if (log_q.size() == 5) begin
            chk("prog_0", log_q[0], 8'h41);
            chk("prog_1", log_q[1], 8'h42);
            chk("prog_2", log_q[2], 8'h81);
            chk("prog_3", log_q[3], 8'h82);
            chk("prog_4", log_q[4], 8'hC0);
        end
        chk("prog_issued", issued_count, 5);
        chk("prog_busy", busy, 0);

        // NOP retired silently, then LOAD_A issues
        log_q.delete();
        push_one(8'h00); push_one(8'h44);
        tick(4);
        chk("nop_len", log_q.size(), 1);
        if (log_q.size() == 1) chk("nop_next", log_q[0], 8'h44);
        chk("nop_seen", nop_seen, 0);
        chk("nop_issued", issued_count, 6);

        // Latency + stall for 3 cycles with stable operands; run dropped mid-issue
        dp_ready = 1'b0;
        push_one(8'h83);
        chk("lat_count_N", fifo_count, 1);
        chk("lat_valid_N", dp_valid, 0);
        tick(1);
        chk("lat_valid_N1", dp_valid, 1);
        chk("lat_count_N1", fifo_count, 0);
        chk("stall_dat_1", {dp_op, dp_operand}, 8'h83);
        run = 1'b0;
        tick(1);
        chk("stall_dat_2", {dp_valid, dp_op, dp_operand}, 9'h183);
        tick(1);
        chk("stall_dat_3", {dp_valid, dp_op, dp_operand}, 9'h183);
        dp_ready = 1'b1;
        tick(1);
        chk("stall_done_valid", dp_valid, 0);
        chk("stall_issued", issued_count, 7);
        run = 1'b1;

        // Handshake in the last permitted ISSUE cycle is a success
        dp_ready = 1'b0;
        push_one(8'h83);
        tick(16);
        chk("edge_valid_16", dp_valid, 1);
        dp_ready = 1'b1;
        tick(1);
        chk("edge_valid_after", dp_valid, 0);
        chk("edge_err", err_timeout, 0);
        chk("edge_issued", issued_count, 8);

        // Timeout abort, HALT accepts pushes, clear_err resumes
        dp_ready = 1'b0;
        push_one(8'h83);
        tick(16);
        chk("to_valid_16", dp_valid, 1);
        chk("to_err_16", err_timeout, 0);
        tick(1);
        chk("to_valid_drop", dp_valid, 0);
        chk("to_err_set", err_timeout, 1);
        chk("to_busy", busy, 1);
        push_one(8'h44);
        tick(2);
        chk("halt_count", fifo_count, 1);
        chk("halt_valid", dp_valid, 0);
        chk("halt_issued", issued_count, 8);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        chk("clr_err", err_timeout, 0);
        chk("clr_valid", dp_valid, 0);
        tick(1);
        chk("resume_dat", {dp_valid, dp_op, dp_operand}, 9'h144);
        dp_ready = 1'b1;
        tick(1);
        chk("resume_issued", issued_count, 9);

        // Fill to 8, reject 9th, reject push at full even with a same-cycle pop
        run = 1'b0;
        log_q.delete();
        for (int i = 1; i <= 8; i++) push_one(8'h40 + 8'(i));
        chk("full_count", fifo_count, 8);
        chk("full_ready", instr_ready, 0);
        push_one(8'h7F);
        chk("full_reject", fifo_count, 8);
        run = 1'b1;
        push_one(8'h7F);
        chk("full_pop_reject", fifo_count, 7);
        tick(20);
        chk("full_drain_len", log_q.size(), 8);
        if (log_q.size() == 8) begin
            chk("full_drain_first", log_q[0], 8'h41);
            chk("full_drain_last", log_q[7], 8'h48);
        end
        chk("full_issued", issued_count, 17);

        // Flush empties the FIFO and discards a same-cycle push
        run = 1'b0;
        push_one(8'h41); push_one(8'h42); push_one(8'h43);
        chk("pre_flush_count", fifo_count, 3);
        flush = 1'b1;
        push_one(8'h44);
        flush = 1'b0;
        chk("flush_count", fifo_count, 0);
        tick(1);
        chk("flush_busy", busy, 0);

        // Asynchronous reset during ISSUE with 3 queued
        dp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(8'h80 + 8'(i));
        run = 1'b1;
        tick(1);
        run = 1'b0;
        chk("pre_rst_state", {dp_valid, fifo_count}, {1'b1, 4'd3});
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", dp_valid, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_ready", instr_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_issued", issued_count, 0);
        chk("arst_dp", {dp_op, dp_operand}, 0);
        tick(2);
        #2 rst_n = 1'b1;
        log_q.delete();
        push_one(8'h45);
        chk("first_push", fifo_count, 1);
        run = 1'b1; dp_ready = 1'b1;
        tick(4);
        chk("post_rst_len", log_q.size(), 1);
        if (log_q.size() == 1) chk("post_rst_dat", log_q[0], 8'h45);
        chk("post_rst_issued", issued_count, 1);
        chk("no_back_to_back", b2b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max cycles dp_valid waits for dp_ready before abort.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 run  in  1  high = sequencer may fetch instructions.
REQ-005 flush  in  1  synchronous FIFO empty request.
REQ-006 clear_err  in  1  synchronous exit from HALT.
REQ-007 instr_in  in  8  instruction, [7:6] opcode, [5:0] operand.
REQ-008 instr_valid  in  1  instr_in offered.
REQ-009 instr_ready  out  1  FIFO can accept (= !full).
REQ-010 dp_op  out  2  opcode issued to MAC datapath.
REQ-011 dp_operand  out  6  operand issued to MAC datapath.
REQ-012 dp_valid  out  1  dp_op/dp_operand valid.
REQ-013 dp_ready  in  1  datapath accepts this cycle.
REQ-014 fifo_count  out  4  occupancy 0..8.
REQ-015 busy  out  1  high when state != IDLE or fifo_count != 0.
REQ-016 issued_count  out  8  handshakes completed, wraps 255->0.
REQ-017 err_timeout  out  1  sticky, set on timeout abort.

Function
REQ-018 Opcodes SHALL be: 00 NOP, 01 LOAD_A, 10 MAC, 11 READ_CLEAR; the sequencer SHALL pass opcode and operand through unmodified.
REQ-019 Instruction FIFO SHALL be 8 x 8 bits, in-order, push when instr_valid && instr_ready.
REQ-020 instr_ready SHALL derive from registered occupancy; push at count 8 SHALL be rejected even if a pop occurs the same cycle.
REQ-021 Simultaneous push and pop with 0 < count < 8 SHALL leave fifo_count unchanged.
REQ-022 Pointers SHALL wrap modulo 8.
REQ-023 flush SHALL set fifo_count to 0 next cycle and discard a same-cycle push; it SHALL NOT affect an instruction already in ISSUE.
REQ-024 FSM states SHALL be IDLE, ISSUE, HALT.
REQ-025 IDLE: if run && fifo_count != 0 && !flush, pop head; NOP SHALL be consumed in that cycle with no issue and stay IDLE; other opcodes SHALL load dp_op/dp_operand and go ISSUE.
REQ-026 ISSUE: dp_valid=1, dp_op/dp_operand held stable until dp_valid && dp_ready; on handshake issued_count increments and state goes IDLE.
REQ-027 dp_valid SHALL be 0 in IDLE and HALT; no back-to-back issue, minimum 2 cycles per issued instruction.
REQ-028 Latency: instruction pushed into empty FIFO at edge N SHALL be popped at edge N+1 and dp_valid SHALL be high after edge N+1 (visible cycle N+1..).
REQ-029 A wait counter SHALL count ISSUE cycles without handshake; on reaching TIMEOUT the FSM SHALL drop dp_valid, set err_timeout, go HALT, instruction lost, issued_count unchanged.
REQ-030 Handshake on the same cycle the counter reaches TIMEOUT SHALL count as success (no error).
REQ-031 HALT: no pops, FIFO still accepts pushes; clear_err SHALL clear err_timeout and return to IDLE next cycle.
REQ-032 Deasserting run SHALL only block new pops; an instruction in ISSUE SHALL complete normally.
REQ-033 NOPs SHALL NOT increment issued_count.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE, fifo_count 0, pointers 0, dp_valid 0, dp_op 0, dp_operand 0, issued_count 0, err_timeout 0, wait counter 0, instr_ready 1, busy 0.
REQ-035 Reset mid-ISSUE SHALL drop dp_valid asynchronously and discard FIFO contents.
REQ-036 First push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-037 run=1, dp_ready=1, push 41,42,81,82,C0 -> dp sequence (01,01),(01,02),(10,01),(10,02),(11,00), issued_count=5, busy=0 at end.
REQ-038 run=0, push 9 instructions back-to-back -> first 8 accepted, instr_ready=0 at count 8, 9th rejected, fifo_count=8.
REQ-039 push 00,44 with dp_ready=1 -> NOP consumed without dp_valid, then (01,04) issued, issued_count=1.
REQ-040 push 83, dp_ready=0 for 16 cycles -> dp_valid drops, err_timeout=1, HALT; pushes still accepted; clear_err -> IDLE, next instruction issues.
REQ-041 push 83, hold dp_ready=0 for 3 cycles -> dp_op/dp_operand stable (10,03) throughout, handshake on 4th, issued_count+1.
REQ-042 rst_n low during ISSUE with fifo_count=3 -> all outputs at reset values same cycle, FIFO empty after release.
